// File: rtl/cpu_pkg.sv
// Shared types and encodings for the instruction-sequencing controller:
// state enum, opcode/sub-op constants, one-hot register/write-back selects.
package cpu_pkg;

    // Controller states
    typedef enum logic [2:0] {
        WAIT      = 3'd0,
        DECODE    = 3'd1,
        WRITE_IMM = 3'd2,
        GET_A     = 3'd3,
        GET_B     = 3'd4,
        EXEC      = 3'd5,
        WRITE_REG = 3'd6,
        ILLEGAL   = 3'd7
    } state_t;

    // Opcode classes
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // MOV-class sub-ops
    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] MOV_IMM = 2'b10;

    // ALU-class sub-ops (identical to ALUop)
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    // One-hot register select
    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    // One-hot write-back source select
    localparam logic [3:0] VSEL_NONE   = 4'b0000;
    localparam logic [3:0] VSEL_MDATA  = 4'b0001;
    localparam logic [3:0] VSEL_SXIMM8 = 4'b0010;
    localparam logic [3:0] VSEL_PC     = 4'b0100;
    localparam logic [3:0] VSEL_DP_OUT = 4'b1000;

    // Latched instruction fields
    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] op;
    } instr_t;

    // Full set of controller outputs
    typedef struct packed {
        logic       w;
        logic       err;
        logic [2:0] nsel;
        logic [3:0] vsel;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic       loadc;
        logic       loads;
        logic       write;
    } ctrl_t;

    // State that DECODE branches to for a given latched instruction
    function automatic state_t decode_target(instr_t i);
        state_t nxt;
        nxt = ILLEGAL;
        if (i.opcode == OPC_MOV) begin
            if (i.op == MOV_IMM)      nxt = WRITE_IMM;
            else if (i.op == MOV_REG) nxt = GET_B;
        end else if (i.opcode == OPC_ALU) begin
            // MVN has a single operand (Rm), so it skips loading A
            nxt = (i.op == ALU_MVN) ? GET_B : GET_A;
        end
        return nxt;
    endfunction

    function automatic logic is_cmp(instr_t i);
        return (i.opcode == OPC_ALU) && (i.op == ALU_CMP);
    endfunction

    function automatic logic is_mov_reg(instr_t i);
        return (i.opcode == OPC_MOV) && (i.op == MOV_REG);
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Instruction request and datapath-control bundle between the sequencer
// (slave side: the controller) and whoever issues instructions (master side).
interface cpu_controller_if;
    import cpu_pkg::*;

    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic       err;
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
    logic       write;

    modport master (
        output s, opcode, op,
        input  w, err, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write
    );

    modport slave (
        input  s, opcode, op,
        output w, err, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write
    );

endinterface

// File: rtl/cpu_controller.sv
// Moore sequencer for a small register-machine datapath: accepts one
// instruction per request in WAIT, walks the read/execute/write-back steps,
// and decodes every control purely from state plus the latched instruction.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    cpu_controller_if.slave bus
);

    state_t state;
    instr_t instr;
    ctrl_t  ctrl;

    // State register and instruction latch; the instruction is captured only in WAIT
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values;
    // the async reset forces WAIT immediately, independent of clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT;
            instr <= '0;
        end else begin
            case (state)
                WAIT: begin
                    if (bus.s) begin
                        instr <= '{opcode: bus.opcode, op: bus.op};
                        state <= DECODE;
                    end
                end
                DECODE:    state <= decode_target(instr);
                WRITE_IMM: state <= WAIT;
                GET_A:     state <= GET_B;
                GET_B:     state <= EXEC;
                EXEC:      state <= is_cmp(instr) ? WAIT : WRITE_REG;
                WRITE_REG: state <= WAIT;
                ILLEGAL:   state <= WAIT;
                default:   state <= WAIT;
            endcase
        end
    end

    // Output decode from current state and latched instruction only
    // NOTE: ctrl is cleared first so every field has a value on every path;
    // without that default the unassigned fields would infer latches.
    always_comb begin
        ctrl = '0;
        case (state)
            WAIT: ctrl.w = 1'b1;
            WRITE_IMM: begin
                ctrl.nsel  = NSEL_RN;
                ctrl.vsel  = VSEL_SXIMM8;
                ctrl.write = 1'b1;
            end
            GET_A: begin
                ctrl.nsel  = NSEL_RN;
                ctrl.loada = 1'b1;
            end
            GET_B: begin
                ctrl.nsel  = NSEL_RM;
                ctrl.loadb = 1'b1;
            end
            EXEC: begin
                // MOV Rd,Rm passes B through with A forced to zero
                ctrl.asel = is_mov_reg(instr);
                ctrl.bsel = 1'b0;
                if (is_cmp(instr)) ctrl.loads = 1'b1;
                else               ctrl.loadc = 1'b1;
            end
            WRITE_REG: begin
                ctrl.nsel  = NSEL_RD;
                ctrl.vsel  = VSEL_DP_OUT;
                ctrl.write = 1'b1;
            end
            ILLEGAL: ctrl.err = 1'b1;
            default: ctrl = '0;
        endcase
    end

    assign bus.w     = ctrl.w;
    assign bus.err   = ctrl.err;
    assign bus.nsel  = ctrl.nsel;
    assign bus.vsel  = ctrl.vsel;
    assign bus.loada = ctrl.loada;
    assign bus.loadb = ctrl.loadb;
    assign bus.asel  = ctrl.asel;
    assign bus.bsel  = ctrl.bsel;
    assign bus.loadc = ctrl.loadc;
    assign bus.loads = ctrl.loads;
    assign bus.write = ctrl.write;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: walks each instruction class state by
// state, measures issue-to-ready latency, and exercises reset and s handling.
module tb_cpu_controller;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    cpu_controller_if bus();

    cpu_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word: {w, err, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write}
    localparam logic [15:0] C_WAIT      = 16'b1_0_000_0000_0000000;
    localparam logic [15:0] C_IDLE0     = 16'b0_0_000_0000_0000000;
    localparam logic [15:0] C_WRITE_IMM = 16'b0_0_001_0010_0000001;
    localparam logic [15:0] C_GET_A     = 16'b0_0_001_0000_1000000;
    localparam logic [15:0] C_GET_B     = 16'b0_0_100_0000_0100000;
    localparam logic [15:0] C_EXEC_ALU  = 16'b0_0_000_0000_0000100;
    localparam logic [15:0] C_EXEC_MOV  = 16'b0_0_000_0000_0010100;
    localparam logic [15:0] C_EXEC_CMP  = 16'b0_0_000_0000_0000010;
    localparam logic [15:0] C_WRITE_REG = 16'b0_0_010_1000_0000001;
    localparam logic [15:0] C_ILLEGAL   = 16'b0_1_000_0000_0000000;

    function automatic logic [15:0] observed();
        return {bus.w, bus.err, bus.nsel, bus.vsel, bus.loada, bus.loadb,
                bus.asel, bus.bsel, bus.loadc, bus.loads, bus.write};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [15:0] exp);
        check(tag, {16'h0, observed()}, {16'h0, exp});
    endtask

    // One rising edge, then settle to the falling edge for sampling/driving
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one instruction from WAIT and count rising edges, including the
    // one that samples s, until w is seen high again.
    task automatic run_latency(input string tag, input logic [2:0] opc,
                               input logic [1:0] sub, input int exp_cycles);
        int cnt;
        bus.s = 1'b1; bus.opcode = opc; bus.op = sub;
        step();
        cnt = 1;
        bus.s = 1'b0;
        while (bus.w !== 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
        check(tag, cnt, exp_cycles);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n      = 1'b0;
        bus.s      = 1'b0;
        bus.opcode = 3'b000;
        bus.op     = 2'b00;

        // Reset state
        #2;
        check_ctl("reset_async", C_WAIT);
        step();
        check_ctl("reset_held", C_WAIT);
        rst_n = 1'b1;

        // s=0 in WAIT holds WAIT
        step();
        check_ctl("hold_wait", C_WAIT);

        // MOV R0,#7
        bus.s = 1'b1; bus.opcode = 3'b110; bus.op = 2'b10;
        step();
        bus.s = 1'b0;
        check_ctl("movi_decode", C_IDLE0);
        step(); check_ctl("movi_write_imm", C_WRITE_IMM);
        step(); check_ctl("movi_wait", C_WAIT);

        // ADD with s held high after issue: ignored outside WAIT
        bus.s = 1'b1; bus.opcode = 3'b101; bus.op = 2'b00;
        step();
        bus.opcode = 3'b110; bus.op = 2'b10;
        check_ctl("add_decode", C_IDLE0);
        step(); check_ctl("add_get_a", C_GET_A);
        step(); check_ctl("add_get_b", C_GET_B);
        step(); check_ctl("add_exec", C_EXEC_ALU);
        bus.s = 1'b0;
        step(); check_ctl("add_write_reg", C_WRITE_REG);
        step(); check_ctl("add_wait", C_WAIT);

        // CMP: status load only, no write-back
        bus.s = 1'b1; bus.opcode = 3'b101; bus.op = 2'b01;
        step();
        bus.s = 1'b0;
        check_ctl("cmp_decode", C_IDLE0);
        step(); check_ctl("cmp_get_a", C_GET_A);
        step(); check_ctl("cmp_get_b", C_GET_B);
        step(); check_ctl("cmp_exec", C_EXEC_CMP);
        step(); check_ctl("cmp_wait", C_WAIT);

        // Unsupported opcode: one-cycle err
        bus.s = 1'b1; bus.opcode = 3'b011; bus.op = 2'b00;
        step();
        bus.s = 1'b0;
        check_ctl("ill_decode", C_IDLE0);
        step(); check_ctl("ill_err", C_ILLEGAL);
        step(); check_ctl("ill_wait", C_WAIT);

        // MVN with opcode changed during GET_B: sequence unaffected
        bus.s = 1'b1; bus.opcode = 3'b101; bus.op = 2'b11;
        step();
        bus.s = 1'b0;
        check_ctl("mvn_decode", C_IDLE0);
        step(); check_ctl("mvn_get_b", C_GET_B);
        bus.opcode = 3'b011; bus.op = 2'b01;
        step(); check_ctl("mvn_exec", C_EXEC_ALU);
        step(); check_ctl("mvn_write_reg", C_WRITE_REG);
        step(); check_ctl("mvn_wait", C_WAIT);

        // Back-to-back MOV Rd,Rm with s held high
        bus.s = 1'b1; bus.opcode = 3'b110; bus.op = 2'b00;
        step(); check_ctl("movr1_decode", C_IDLE0);
        step(); check_ctl("movr1_get_b", C_GET_B);
        step(); check_ctl("movr1_exec", C_EXEC_MOV);
        step(); check_ctl("movr1_write_reg", C_WRITE_REG);
        step(); check_ctl("movr1_wait", C_WAIT);
        step(); check_ctl("movr2_decode", C_IDLE0);
        step(); check_ctl("movr2_get_b", C_GET_B);
        step(); check_ctl("movr2_exec", C_EXEC_MOV);
        bus.s = 1'b0;
        step(); check_ctl("movr2_write_reg", C_WRITE_REG);
        step(); check_ctl("movr2_wait", C_WAIT);
        step(); check_ctl("movr2_hold", C_WAIT);

        // Latency table
        run_latency("lat_mov_imm", 3'b110, 2'b10, 3);
        run_latency("lat_mov_reg", 3'b110, 2'b00, 5);
        run_latency("lat_mvn",     3'b101, 2'b11, 5);
        run_latency("lat_add",     3'b101, 2'b00, 6);
        run_latency("lat_and",     3'b101, 2'b10, 6);
        run_latency("lat_cmp",     3'b101, 2'b01, 5);
        run_latency("lat_ill_011", 3'b011, 2'b00, 3);
        run_latency("lat_ill_mov01", 3'b110, 2'b01, 3);
        run_latency("lat_ill_mov11", 3'b110, 2'b11, 3);

        // Reset mid-EXEC of ADD
        bus.s = 1'b1; bus.opcode = 3'b101; bus.op = 2'b00;
        step();
        bus.s = 1'b0;
        step(); step(); step();
        check_ctl("rst_pre_exec", C_EXEC_ALU);
        #2 rst_n = 1'b0;
        #1 check_ctl("rst_mid_exec", C_WAIT);
        check("rst_instr_clear", {27'h0, dut.instr}, 32'h0);
        step();
        check_ctl("rst_mid_held", C_WAIT);
        rst_n = 1'b1;
        step(); check_ctl("rst_after1", C_WAIT);
        step(); check_ctl("rst_after2", C_WAIT);

        // First instruction after reset accepted on the first s edge
        run_latency("lat_and_after_rst", 3'b101, 2'b10, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port s, input, 1 bit: start request for one instruction.
REQ-004 The block SHALL have port opcode, input, 3 bits: instruction opcode (110 = MOV class, 101 = ALU class).
REQ-005 The block SHALL have port op, input, 2 bits: sub-op; for the ALU class it equals ALUop (00 ADD, 01 CMP, 10 AND, 11 MVN).
REQ-006 The block SHALL have port w, output, 1 bit: idle/ready flag, high only in WAIT.
REQ-007 The block SHALL have port err, output, 1 bit: one-cycle pulse on an unsupported encoding.
REQ-008 The block SHALL have port nsel, output, 3 bits, one-hot register select: 001 Rn, 010 Rd, 100 Rm, 000 none.
REQ-009 The block SHALL have port vsel, output, 4 bits, one-hot write-back source: 0001 mdata, 0010 sximm8, 0100 PC, 1000 datapath_out.
REQ-010 The block SHALL have outputs loada, loadb, asel, bsel, loadc, loads, write, 1 bit each: datapath controls.

Function
REQ-011 The block SHALL be a Moore FSM: every output is decoded from the current state plus the latched instruction only, never from live inputs.
REQ-012 States SHALL be WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG, ILLEGAL.
REQ-013 In WAIT with s=1, the block SHALL latch opcode/op into an internal register and go to DECODE; later changes on opcode/op SHALL be ignored until the next WAIT.
REQ-014 DECODE SHALL branch as follows: 110/10 -> WRITE_IMM; 110/00 -> GET_B; 101/00, 101/01, 101/10 -> GET_A; 101/11 -> GET_B; any other encoding -> ILLEGAL.
REQ-015 WRITE_IMM SHALL drive nsel=001, vsel=0010, write=1, then go to WAIT.
REQ-016 GET_A SHALL drive nsel=001, loada=1, then go to GET_B.
REQ-017 GET_B SHALL drive nsel=100, loadb=1, then go to EXEC.
REQ-018 EXEC SHALL drive bsel=0, and asel=1 for MOV Rd,Rm, else asel=0.
REQ-019 For CMP, EXEC SHALL drive loads=1, loadc=0, then go to WAIT; for all other instructions it SHALL drive loadc=1, loads=0, then go to WRITE_REG.
REQ-020 WRITE_REG SHALL drive nsel=010, vsel=1000, write=1, then go to WAIT.
REQ-021 ILLEGAL SHALL drive err=1 with all datapath controls 0, then go to WAIT; no register write or status update SHALL occur.
REQ-022 Any control not named for a state SHALL be 0 in that state; vsel=0000 and nsel=000 when not writing or reading.
REQ-023 Latency, counted from the rising edge sampling s=1 in WAIT to w high again:
  - MOV imm: 3 cycles.
  - MOV reg / MVN: 5 cycles.
  - ADD / AND: 6 cycles.
  - CMP: 5 cycles.
  - Illegal: 3 cycles.
REQ-024 If s=1 on the cycle w returns high, the next instruction SHALL start on that edge (back-to-back, no bubble); s=0 in WAIT SHALL hold WAIT.
REQ-025 s SHALL be ignored in every state other than WAIT.
REQ-026 write and loadc SHALL never be high in the same cycle; loada and loadb SHALL never be high together.

Reset
REQ-027 While rst_n=0, the state SHALL be WAIT immediately (asynchronous), with w=1 and err, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write all 0.
REQ-028 Reset asserted mid-instruction SHALL abort it with no further write, load or status update; the latched instruction SHALL clear to 000/00.
REQ-029 After rst_n rises, the first instruction SHALL be accepted on the first rising edge with s=1.

Structure
REQ-030 Shared package cpu_pkg SHALL hold the state enum, the opcode/op constants, and the nsel/vsel one-hot encodings; the datapath and top level SHALL use the same encodings.
REQ-031 No sub-module is needed: one sequential process (state plus instruction latch) and one combinational output decoder.

Verification
REQ-032 Reset mid-EXEC of ADD -> all controls 0, w=1 immediately; no write or loadc after release.
REQ-033 MOV R0,#7 (110/10), s pulse -> DECODE, then WRITE_IMM with nsel=001, vsel=0010, write=1, then w=1 three cycles after the s edge.
REQ-034 ADD (101/00) -> GET_A (loada, nsel=001), GET_B (loadb, nsel=100), EXEC (asel=0, loadc), WRITE_REG (nsel=010, vsel=1000, write); w high after 6 cycles.
REQ-035 CMP (101/01) -> EXEC with loads=1, loadc=0; write never asserted; return to WAIT.
REQ-036 Opcode 011 -> ILLEGAL with err=1 for exactly one cycle, no loads or writes; opcode changed during GET_B of MVN -> sequence unaffected.
REQ-037 s held high across two MOV-reg instructions -> second DECODE directly after return to WAIT; asel=1 in both EXEC cycles.
